// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - tile codes, palette and default geometry for the tile renderer
package tile_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_BODY  = 2'd1,
    TILE_HEAD  = 2'd2,
    TILE_FOOD  = 2'd3
  } tile_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam logic [7:0] COLOUR_EMPTY = 8'h00;
  localparam logic [7:0] COLOUR_BODY  = 8'h1C;
  localparam logic [7:0] COLOUR_HEAD  = 8'hFC;
  localparam logic [7:0] COLOUR_FOOD  = 8'hE0;
  localparam logic [7:0] GRID_COLOUR  = 8'h49;

  localparam int DEF_TILE_SHIFT = 4;
  localparam int DEF_COLS       = 40;
  localparam int DEF_ROWS       = 30;

  function automatic logic [7:0] tile_colour(input logic [1:0] code);
    logic [7:0] c;
    case (code)
      TILE_EMPTY: c = COLOUR_EMPTY;
      TILE_BODY:  c = COLOUR_BODY;
      TILE_HEAD:  c = COLOUR_HEAD;
      default:    c = COLOUR_FOOD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tile_ram.sv
// rtl/tile_ram.sv - 2-bit tile map, one write port and one registered read port, no reset
module tile_ram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11
) (
  input  logic          VGA_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge VGA_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - 3-stage tile-map pixel renderer with write port and bulk clear
// Optional grid overlay on empty tiles when TILE_GRID_EN is defined.
module tile_renderer
  import tile_pkg::*;
#(
  parameter int TILE_SHIFT = DEF_TILE_SHIFT,
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS
) (
  input  logic        VGA_clk,
  input  logic        rst_n,
  input  logic [9:0]  xCount,
  input  logic [9:0]  yCount,
  input  logic        display,
  input  logic        VGA_hSync_in,
  input  logic        VGA_vSync_in,
  input  logic        wr_valid,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_data,
  output logic        wr_ready,
  input  logic        clear_req,
  output logic        busy,
  output logic [7:0]  rgb,
  output logic        VGA_hSync,
  output logic        VGA_vSync,
  output logic        frame_start
);

  localparam int          DEPTH     = COLS * ROWS;
  localparam logic [11:0] DEPTH_W   = 12'(DEPTH);
  localparam logic [10:0] LAST_ADDR = 11'(DEPTH - 1);

  clr_state_e  state_q, state_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;
  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [1:0]  ram_wdata;

  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // A clear request pre-empts a same-cycle user write by dropping wr_ready.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    case (state_q)
      ST_IDLE: begin
        wr_ready = !clear_req;
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else begin
          ram_we = wr_valid && ({1'b0, wr_addr} < DEPTH_W);
        end
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = TILE_EMPTY;
        clr_cnt_d = clr_cnt_q + 11'd1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  logic [9:0]  tile_x, tile_y;
  logic [10:0] pix_addr;
  logic [10:0] rd_addr_q;
  logic [1:0]  code;
  logic [7:0]  pix_colour;
  logic [2:0]  disp_q, hs_q, vs_q, org_q;

  assign tile_x   = xCount >> TILE_SHIFT;
  assign tile_y   = yCount >> TILE_SHIFT;
  assign pix_addr = 11'(32'(tile_y) * COLS + 32'(tile_x));

  tile_ram #(
    .DEPTH(DEPTH),
    .AW   (11)
  ) u_ram (
    .VGA_clk(VGA_clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr  (rd_addr_q),
    .rdata  (code)
  );

`ifdef TILE_GRID_EN
  logic       on_grid;
  logic [1:0] grid_q;

  assign on_grid = display &&
                   ((xCount[TILE_SHIFT-1:0] == '0) || (yCount[TILE_SHIFT-1:0] == '0));

  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      grid_q <= '0;
    end else begin
      grid_q <= {grid_q[0], on_grid};
    end
  end

  assign pix_colour = ((code == TILE_EMPTY) && grid_q[1]) ? GRID_COLOUR : tile_colour(code);
`else
  assign pix_colour = tile_colour(code);
`endif

  // Index 0 aligns with the address register, 1 with the RAM output, 2 with rgb.
  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      disp_q    <= '0;
      hs_q      <= '1;
      vs_q      <= '1;
      org_q     <= '0;
      rgb       <= 8'h00;
    end else begin
      rd_addr_q <= display ? pix_addr : '0;
      disp_q    <= {disp_q[1:0], display};
      hs_q      <= {hs_q[1:0], VGA_hSync_in};
      vs_q      <= {vs_q[1:0], VGA_vSync_in};
      org_q     <= {org_q[1:0], (xCount == 10'd0) && (yCount == 10'd0)};
      rgb       <= disp_q[1] ? pix_colour : 8'h00;
    end
  end

  assign VGA_hSync   = hs_q[2];
  assign VGA_vSync   = vs_q[2];
  assign frame_start = org_q[2];

endmodule

// File: tb/tb_tile_renderer.sv
// tb/tb_tile_renderer.sv - directed self-checking bench for tile_renderer
module tb_tile_renderer;

  logic        VGA_clk = 1'b0;
  logic        rst_n;
  logic [9:0]  xCount, yCount;
  logic        display, VGA_hSync_in, VGA_vSync_in;
  logic        wr_valid;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic        wr_ready, clear_req, busy;
  logic [7:0]  rgb;
  logic        VGA_hSync, VGA_vSync, frame_start;

  always #5 VGA_clk = ~VGA_clk;

  tile_renderer dut (
    .VGA_clk     (VGA_clk),
    .rst_n       (rst_n),
    .xCount      (xCount),
    .yCount      (yCount),
    .display     (display),
    .VGA_hSync_in(VGA_hSync_in),
    .VGA_vSync_in(VGA_vSync_in),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .clear_req   (clear_req),
    .busy        (busy),
    .rgb         (rgb),
    .VGA_hSync   (VGA_hSync),
    .VGA_vSync   (VGA_vSync),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       disp;
    logic       hs;
    logic       vs;
  } pix_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] model [1200];
  pix_t       stim [$];
  int         busy_cycles;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge VGA_clk);
    #1;
  endtask

  function automatic logic [7:0] exp_colour(input logic [1:0] c);
    case (c)
      2'd0:    return 8'h00;
      2'd1:    return 8'h1C;
      2'd2:    return 8'hFC;
      default: return 8'hE0;
    endcase
  endfunction

  function automatic logic [7:0] exp_rgb(input pix_t p);
    int a;
    if (!p.disp) return 8'h00;
    a = (int'(p.y) / 16) * 40 + int'(p.x) / 16;
`ifdef TILE_GRID_EN
    if (model[a] == 2'd0 && ((int'(p.x) % 16) == 0 || (int'(p.y) % 16) == 0)) return 8'h49;
`endif
    return exp_colour(model[a]);
  endfunction

  task automatic apply(input pix_t p);
    xCount       = p.x;
    yCount       = p.y;
    display      = p.disp;
    VGA_hSync_in = p.hs;
    VGA_vSync_in = p.vs;
  endtask

  task automatic push_pix(input int x, input int y, input logic d, input logic hs, input logic vs);
    pix_t p;
    p.x = 10'(x); p.y = 10'(y); p.disp = d; p.hs = hs; p.vs = vs;
    stim.push_back(p);
  endtask

  task automatic push_tile(input int a);
    push_pix((a % 40) * 16 + 8, (a / 40) * 16 + 8, 1'b1, 1'b1, 1'b1);
  endtask

  // Streams one pixel per cycle; outputs for entry j are due after the third edge.
  task automatic run_stream(input string tag, input bit chk_sync);
    int   n;
    pix_t p;
    pix_t blank;
    n = stim.size();
    blank.x = 10'd700; blank.y = 10'd500; blank.disp = 1'b0; blank.hs = 1'b1; blank.vs = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) apply(stim[i]); else apply(blank);
      step();
      if (i >= 2) begin
        p = stim[i-2];
        check_val($sformatf("%s rgb (%0d,%0d)", tag, p.x, p.y), {24'd0, rgb}, {24'd0, exp_rgb(p)});
        if (chk_sync) begin
          check_val($sformatf("%s hsync %0d", tag, i-2), {31'd0, VGA_hSync}, {31'd0, p.hs});
          check_val($sformatf("%s vsync %0d", tag, i-2), {31'd0, VGA_vSync}, {31'd0, p.vs});
          check_val($sformatf("%s frame_start %0d", tag, i-2), {31'd0, frame_start},
                    {31'd0, (p.x == 10'd0 && p.y == 10'd0)});
        end
      end
    end
    stim.delete();
  endtask

  task automatic do_write(input int a, input logic [1:0] d);
    wr_valid = 1'b1;
    wr_addr  = 11'(a);
    wr_data  = d;
    #1;
    check_val($sformatf("wr_ready at write %0d", a), {31'd0, wr_ready}, 32'd1);
    @(posedge VGA_clk);
    #1;
    wr_valid = 1'b0;
    if (a < 1200) model[a] = d;
  endtask

  // Pulses clear_req (optionally with a colliding write), re-requests at cycle 500,
  // optionally resets at cycle rst_at, and counts busy cycles.
  task automatic run_clear(input int rst_at, input bit collide, output int cycles);
    int bad;
    bad = 0;
    clear_req = 1'b1;
    if (collide) begin
      wr_valid = 1'b1; wr_addr = 11'd5; wr_data = 2'd3;
      #1;
      check_val("wr_ready on clear collision", {31'd0, wr_ready}, 32'd0);
    end
    step();
    clear_req = 1'b0;
    wr_valid  = 1'b0;
    cycles    = 0;
    while (busy && cycles < 1300) begin
      if (wr_ready) bad++;
      if (cycles == 500) clear_req = 1'b1;
      if (cycles == rst_at) rst_n = 1'b0;
      step();
      clear_req = 1'b0;
      rst_n     = 1'b1;
      cycles++;
    end
    check_val("wr_ready low during clear", 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    xCount = '0; yCount = '0; display = 1'b1; VGA_hSync_in = 1'b1; VGA_vSync_in = 1'b1;
    step();
    step();
    check_val("reset rgb", {24'd0, rgb}, 32'h00);
    check_val("reset frame_start", {31'd0, frame_start}, 32'd0);
    check_val("reset hsync", {31'd0, VGA_hSync}, 32'd1);
    check_val("reset vsync", {31'd0, VGA_vSync}, 32'd1);
    check_val("reset busy", {31'd0, busy}, 32'd0);
    check_val("reset wr_ready", {31'd0, wr_ready}, 32'd1);
    rst_n = 1'b1; display = 1'b0; xCount = 10'd700; yCount = 10'd500;
    step();

    // Full clear, with an ignored re-request mid-way.
    run_clear(-1, 1'b0, busy_cycles);
    check_val("clear busy cycles", 32'(busy_cycles), 32'd1200);
    check_val("wr_ready after clear", {31'd0, wr_ready}, 32'd1);
    for (int a = 0; a < 1200; a++) model[a] = 2'd0;
    for (int a = 0; a < 1200; a++) push_tile(a);
    run_stream("cleared map", 1'b0);

    do_write(41, 2'd2);
    do_write(0, 2'd1);
    do_write(1199, 2'd3);
    do_write(700, 2'd1);
    do_write(599, 2'd2);
    do_write(5, 2'd1);
    push_pix(16, 16, 1'b1, 1'b1, 1'b1);
    push_pix(31, 31, 1'b1, 1'b1, 1'b1);
    push_tile(40); push_tile(42); push_tile(1); push_tile(81);
    push_tile(0); push_tile(1199); push_tile(700); push_tile(599); push_tile(5);
    run_stream("tiles", 1'b0);

    // Out-of-range writes complete the handshake and leave the map alone.
    do_write(1200, 2'd3);
    do_write(2047, 2'd3);
    for (int a = 0; a < 1200; a++) push_tile(a);
    run_stream("after oor", 1'b0);

    // Colliding write must not land; abort the clear early so tile 5 stays visible.
    run_clear(3, 1'b1, busy_cycles);
    check_val("collide abort busy cycles", 32'(busy_cycles), 32'd4);
    for (int a = 0; a < 3; a++) model[a] = 2'd0;
    push_tile(5); push_tile(0); push_tile(1); push_tile(2); push_tile(41);
    run_stream("collision", 1'b0);

    // Reset at clear cycle 600.
    run_clear(600, 1'b0, busy_cycles);
    check_val("abort busy cycles", 32'(busy_cycles), 32'd601);
    check_val("abort busy low", {31'd0, busy}, 32'd0);
    check_val("abort wr_ready", {31'd0, wr_ready}, 32'd1);
    for (int a = 0; a < 600; a++) model[a] = 2'd0;
    push_tile(599); push_tile(598); push_tile(41); push_tile(700); push_tile(1199);
    run_stream("abort", 1'b0);

    // Sync delay, frame_start and blanking.
    do_write(0, 2'd1);
    do_write(1, 2'd3);
    push_pix(630, 479, 1'b1, 1'b1, 1'b1);
    push_pix(700, 479, 1'b0, 1'b0, 1'b1);
    push_pix(750, 500, 1'b0, 1'b0, 1'b0);
    push_pix(799, 524, 1'b0, 1'b1, 1'b0);
    push_pix(0,   0,   1'b1, 1'b1, 1'b1);
    push_pix(8,   0,   1'b1, 1'b1, 1'b1);
    push_pix(24,  8,   1'b1, 1'b0, 1'b1);
    push_pix(32,  40,  1'b1, 1'b1, 1'b1);
    push_pix(40,  40,  1'b1, 1'b1, 1'b0);
    push_pix(100, 100, 1'b0, 1'b1, 1'b1);
    run_stream("sync", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tile_renderer.md
TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 Parameter TILE_SHIFT, default 4, log2 of tile edge in pixels (16x16 tiles).
REQ-002 Parameter COLS, default 40, tiles per row; parameter ROWS, default 30, tile rows; map depth = COLS*ROWS = 1200.
REQ-003 VGA_clk  input  1  pixel clock, also the write-port clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 xCount, yCount  input  10 each  pixel position from the VGA timing generator.
REQ-006 display  input  1  active-video flag, same cycle alignment as xCount/yCount.
REQ-007 VGA_hSync_in, VGA_vSync_in  input  1 each  active-low syncs from the generator.
REQ-008 wr_valid  input  1; wr_addr  input  11; wr_data  input  2; wr_ready  output  1 -- tile-map write handshake.
REQ-009 clear_req  input  1  single-cycle request to zero the whole map.
REQ-010 busy  output  1  high while a clear is running.
REQ-011 rgb  output  8  pixel colour, R[7:5] G[4:2] B[1:0].
REQ-012 VGA_hSync, VGA_vSync  output  1 each  syncs delayed to align with rgb.
REQ-013 frame_start  output  1  one-cycle pulse aligned with the rgb of pixel (0,0).

Function
REQ-014 Tile codes: 0 empty, 1 body, 2 head, 3 food; palette 8'h00, 8'h1C, 8'hFC, 8'hE0.
REQ-015 Render pipeline is 3 cycles. Stage 1 registers addr = (yCount>>TILE_SHIFT)*COLS + (xCount>>TILE_SHIFT). Stage 2 performs the registered map read. Stage 3 registers the palette colour into rgb.
REQ-016 display, both syncs and the (0,0) detect travel through a matching 3-stage delay; rgb is 8'h00 whenever the delayed display is low.
REQ-017 When display is low, the stage-1 address is forced to 0.
REQ-018 A write transfers on a cycle where wr_valid && wr_ready; the written value is visible to reads starting the following cycle.
REQ-019 A transfer with wr_addr >= COLS*ROWS completes the handshake but does not modify the map.
REQ-020 FSM states:
- IDLE: wr_ready = 1, busy = 0; clear_req moves to CLEAR with clear counter = 0.
- CLEAR: wr_ready = 0, busy = 1; writes 0 at the counter address each cycle and increments the counter; after writing address COLS*ROWS-1, returns to IDLE.
REQ-021 A clear takes exactly COLS*ROWS cycles (1200 at defaults); busy falls on the cycle after the last clear write.
REQ-022 clear_req and wr_valid in the same IDLE cycle: the clear wins, wr_ready is driven 0 that cycle, and no user write occurs.
REQ-023 clear_req while in CLEAR is ignored and does not restart the counter.
REQ-024 Rendering continues during CLEAR; pixels show a mix of old and cleared tiles, which is acceptable.

Reset
REQ-025 While rst_n = 0 at a clock edge: FSM to IDLE, counter 0, rgb 8'h00, frame_start 0, all pipeline display bits 0, delayed syncs 1 (inactive).
REQ-026 Map contents are not reset; reset mid-clear aborts the clear and leaves the map partially cleared.

Configuration
REQ-027 Macro TILE_GRID_EN:
- Defined: empty-tile pixels whose x[TILE_SHIFT-1:0] == 0 or y[TILE_SHIFT-1:0] == 0 render 8'h49, with the offset bits pipelined to stage 3.
- Undefined: no grid and no extra pipeline bits; latency is 3 cycles either way.

Structure
REQ-028 Package tile_pkg holds the tile-code constants, the palette constants, GRID_COLOUR, and the default COLS/ROWS/TILE_SHIFT.
REQ-029 Sub-module tile_ram: simple dual-port, 1 write port and 1 registered read port, 2 bits x COLS*ROWS, no reset.

Verification
REQ-030 Clear, then write addr 41 = 2; when the generator reaches x=16, y=16 (or any pixel of that tile), rgb = 8'hFC exactly 3 cycles later, and neighbouring tiles show 8'h00.
REQ-031 Pulse clear_req: busy is high for 1200 cycles, wr_ready = 0 throughout; afterwards every visible pixel is 8'h00 (8'h49 on grid lines when TILE_GRID_EN is defined).
REQ-032 clear_req together with wr_valid (addr 5, data 3) in the same cycle: wr_ready = 0, no write occurs, and tile 5 reads 0 after the clear.
REQ-033 Write to addr 1200 and addr 2047: the handshake completes and a full-map readback is unchanged.
REQ-034 Syncs: each output sync edge occurs exactly 3 cycles after the corresponding input edge; frame_start pulses once per frame, 3 cycles after (0,0) is presented; rgb = 0 during blanking.
REQ-035 Assert rst_n low at clear cycle 600: FSM returns to IDLE, busy falls on the next cycle, addr 599 reads 0, and addr 700 retains its pre-clear value.
